systolic_feed_controller: RTL
=============================

# systolic_feed_controller

Sequencer that sits in front of the `systolic_array` datapath and runs one complete matrix multiplication per `start`. It holds operand matrices A and B, clears the array, feeds the skewed operand wavefront, waits for `computation_done`, and captures the C result. The captured result is held in a readable buffer. A host loads operands and reads results through simple element-addressed ports.

## Interface

**Parameters**
- `DATA_WIDTH`, 8, operand element width (unsigned).
- `ARRAY_SIZE`, 3, N; matrices are NxN.
- `ACCUMULATOR_WIDTH`, 2*DATA_WIDTH+$clog2(ARRAY_SIZE), result element width.
- `TIMEOUT_CYCLES`, 64, maximum number of WAIT cycles before the run is aborted.

**Ports** (IW = $clog2(ARRAY_SIZE))
- `clk`  in  1  single clock; all logic is on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `load_valid`  in  1  write one operand element.
- `load_sel`  in  1  selects the target matrix: 0=A, 1=B.
- `load_row`, `load_col`  in  IW each  element address.
- `load_data`  in  DATA_WIDTH  element value.
- `load_ready`  out  1  high only in IDLE; `load_valid` is ignored when low.
- `start`  in  1  begin a run; sampled only in IDLE.
- `busy`  out  1  high in CLEAR, FEED, WAIT and DONE.
- `done`  out  1  one-cycle pulse at the end of a run.
- `error`  out  1  set on timeout; sticky until the next accepted `start`.
- `res_valid`  out  1  result buffer holds a successful run.
- `res_row`, `res_col`  in  IW each  result read address.
- `res_data`  out  ACCUMULATOR_WIDTH  combinational read of result[res_row][res_col].
- `arr_clear`  out  1  one-cycle pulse that clears the array accumulators; the integrator merges it into the array's reset.
- `arr_enable`  out  1  array enable.
- `arr_a`  out  N*DATA_WIDTH  left-edge operand lanes; lane i is at bits [i*DATA_WIDTH +: DATA_WIDTH].
- `arr_b`  out  N*DATA_WIDTH  top-edge operand lanes, same packing as `arr_a`.
- `arr_c`  in  N*N*ACCUMULATOR_WIDTH  array outputs; element (i,j) is at index i*N+j.
- `arr_done`  in  1  array `computation_done`.

## Operation

**States:** IDLE, CLEAR, FEED, WAIT, DONE.

- **IDLE**
  - An element write occurs when `load_valid` is high: A or B[load_row][load_col] <= `load_data`.
  - `start`=1 moves to CLEAR. Accepting `start` clears `error` and `res_valid`.
  - If `load_valid` and `start` are high in the same cycle, the write is performed and the run uses the new value.
- **CLEAR**
  - `arr_clear`=1 for exactly one cycle, then FEED. Feed counter t <= 0.
- **FEED**
  - Lasts 2N cycles, t = 0..2N-1.
  - `arr_a` lane i = A[i][t-i] when 0 <= t-i < N, else 0.
  - `arr_b` lane j = B[t-j][j] when 0 <= t-j < N, else 0.
  - After t = 2N-1, move to WAIT with the wait counter at 0.
- **WAIT**
  - Lanes are driven to 0.
  - `arr_done`=1: latch all N*N `arr_c` values into the result buffer, set `res_valid`, go to DONE.
  - Otherwise, when the wait counter reaches TIMEOUT_CYCLES-1: set `error`, leave the result buffer unchanged, go to DONE.
- **DONE**
  - `done`=1 for one cycle, then IDLE.

**Output rules**
- `arr_enable` = 1 in FEED, WAIT and DONE; 0 in IDLE and CLEAR.
- `arr_a`/`arr_b` are 0 outside FEED.

**Other behaviour**
- `arr_done` is ignored in every state except WAIT. A stale done from the previous run must not end the new run.
- `start` is ignored while `busy`=1.
- Results are stored at full ACCUMULATOR_WIDTH with no truncation.
- Result contents and `res_valid` persist until the next accepted `start`.

**Reset**
- Reset has priority over everything and may occur in any state, including mid-FEED; the next state is IDLE.
- Reset values: `busy`=0, `done`=0, `error`=0, `res_valid`=0, `arr_clear`=0, `arr_enable`=0, `arr_a`=`arr_b`=0, `load_ready`=1, result buffer all 0.
- A/B storage is not reset and retains its contents.

## Timing

- `start` high in cycle 0 (IDLE): cycle 1 = CLEAR, cycles 2..2N+1 = FEED, WAIT from cycle 2N+2.
- `arr_a`, `arr_b`, `arr_enable`, `arr_clear` and `done` are registered and valid for the whole cycle of their state; they are decoded from next-state at the clock edge.
- If `arr_done` is first high in WAIT cycle w: C is latched at the end of cycle w, DONE is cycle w+1 (`done`=1, `res_valid`=1), IDLE is cycle w+2.
- Timeout: WAIT occupies exactly TIMEOUT_CYCLES cycles, followed by one DONE cycle with `error`=1.
- Minimum run for N=3, with `arr_done` high in the first WAIT cycle: `done` in cycle 9; next `start` accepted in cycle 10.
- `res_data` has zero latency from `res_row`/`res_col`.

## Test plan

- **Identity:** A=I, B rows {1,2,3},{4,5,6},{7,8,9}, run against `systolic_array` (N=3) → `done` pulse, `res_valid`=1, result equals B, `error`=0.
- **Width:** all A and B elements 9 → every result element 243, with no overflow in 18 bits.
- **Skew:** A[i][k]=10*i+k, B[k][j]=20+10*k+j, array stubbed → in FEED t=2, `arr_a` lanes {2,11,20} and `arr_b` lanes {40,31,22}; at t=5 all lanes 0; `arr_clear` pulses exactly once, in cycle 1.
- **Timeout:** stub holds `arr_done`=0, TIMEOUT_CYCLES=64 → `done` exactly 64 cycles after WAIT entry, `error`=1, `res_valid`=0, result buffer unchanged. The next `start` clears `error`.
- **Ignore rules:**
  - `start` and `load_valid` pulsed mid-FEED → no restart and no operand change.
  - `arr_done` held high during FEED → the run still completes all 2N FEED cycles before capture.
- **Reset mid-FEED at t=3** → next cycle IDLE, `busy`=0, all lanes 0, `res_valid`=0; a rerun without reloading gives the correct product.

Source files
------------

// File: rtl/systolic_feed_controller.sv
`default_nettype none
// ============================================================================
// systolic_feed_controller: runs one skewed-wavefront matmul per start
// Revision: 1.0
// ============================================================================
module systolic_feed_controller #(
  parameter int DATA_WIDTH        = 8,
  parameter int ARRAY_SIZE        = 3,
  parameter int ACCUMULATOR_WIDTH = 2*DATA_WIDTH + $clog2(ARRAY_SIZE),
  parameter int TIMEOUT_CYCLES    = 64,
  localparam int IW               = (ARRAY_SIZE > 1) ? $clog2(ARRAY_SIZE) : 1
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          load_valid,
  input  logic                                          load_sel,
  input  logic [IW-1:0]                                 load_row,
  input  logic [IW-1:0]                                 load_col,
  input  logic [DATA_WIDTH-1:0]                         load_data,
  output logic                                          load_ready,
  input  logic                                          start,
  output logic                                          busy,
  output logic                                          done,
  output logic                                          error,
  output logic                                          res_valid,
  input  logic [IW-1:0]                                 res_row,
  input  logic [IW-1:0]                                 res_col,
  output logic [ACCUMULATOR_WIDTH-1:0]                  res_data,
  output logic                                          arr_clear,
  output logic                                          arr_enable,
  output logic [ARRAY_SIZE*DATA_WIDTH-1:0]              arr_a,
  output logic [ARRAY_SIZE*DATA_WIDTH-1:0]              arr_b,
  input  logic [ARRAY_SIZE*ARRAY_SIZE*ACCUMULATOR_WIDTH-1:0] arr_c,
  input  logic                                          arr_done
);

  localparam int TW = $clog2(2*ARRAY_SIZE) + 1;
  localparam int WW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TW-1:0] LAST_T = TW'(2*ARRAY_SIZE - 1);
  localparam logic [WW-1:0] LAST_W = WW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_FEED  = 3'd2,
    S_WAIT  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t state_q, state_d;
  logic [TW-1:0] t_q, t_d;
  logic [WW-1:0] w_q, w_d;
  logic [ARRAY_SIZE*DATA_WIDTH-1:0] arr_a_q, arr_a_d, arr_b_q, arr_b_d;
  logic arr_clear_q, arr_enable_q, done_q, error_q, res_valid_q;

  logic [DATA_WIDTH-1:0]        a_mem [ARRAY_SIZE][ARRAY_SIZE];
  logic [DATA_WIDTH-1:0]        b_mem [ARRAY_SIZE][ARRAY_SIZE];
  logic [ACCUMULATOR_WIDTH-1:0] res_q [ARRAY_SIZE][ARRAY_SIZE];

  logic accept_start, capture, timeout;

  assign accept_start = (state_q == S_IDLE) && start;
  assign capture      = (state_q == S_WAIT) && arr_done;
  assign timeout      = (state_q == S_WAIT) && !arr_done && (w_q == LAST_W);

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    w_d     = w_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_CLEAR;
      S_CLEAR: begin
        state_d = S_FEED;
        t_d     = '0;
      end
      S_FEED: begin
        if (t_q == LAST_T) begin
          state_d = S_WAIT;
          w_d     = '0;
        end else begin
          t_d = t_q + TW'(1);
        end
      end
      S_WAIT: begin
        if (capture || timeout) state_d = S_DONE;
        else                    w_d     = w_q + WW'(1);
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Lanes are registered, so they are decoded from the next feed step t_d.
  always_comb begin
    int k;
    k       = 0;
    arr_a_d = '0;
    arr_b_d = '0;
    if (state_d == S_FEED) begin
      for (int i = 0; i < ARRAY_SIZE; i++) begin
        k = int'(t_d) - i;
        if (k >= 0 && k < ARRAY_SIZE) begin
          arr_a_d[i*DATA_WIDTH +: DATA_WIDTH] = a_mem[i][IW'(k)];
          arr_b_d[i*DATA_WIDTH +: DATA_WIDTH] = b_mem[IW'(k)][i];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      t_q          <= '0;
      w_q          <= '0;
      arr_a_q      <= '0;
      arr_b_q      <= '0;
      arr_clear_q  <= 1'b0;
      arr_enable_q <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      res_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      t_q          <= t_d;
      w_q          <= w_d;
      arr_a_q      <= arr_a_d;
      arr_b_q      <= arr_b_d;
      arr_clear_q  <= (state_d == S_CLEAR);
      arr_enable_q <= (state_d == S_FEED) || (state_d == S_WAIT) || (state_d == S_DONE);
      done_q       <= (state_d == S_DONE);
      if (accept_start) begin
        error_q     <= 1'b0;
        res_valid_q <= 1'b0;
      end else begin
        if (timeout) error_q     <= 1'b1;
        if (capture) res_valid_q <= 1'b1;
      end
    end
  end

  // Operand storage deliberately survives reset so a run can be repeated.
  always_ff @(posedge clk) begin
    if ((state_q == S_IDLE) && load_valid) begin
      if (load_sel) b_mem[load_row][load_col] <= load_data;
      else          a_mem[load_row][load_col] <= load_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ARRAY_SIZE; i++)
        for (int j = 0; j < ARRAY_SIZE; j++)
          res_q[i][j] <= '0;
    end else if (capture) begin
      for (int i = 0; i < ARRAY_SIZE; i++)
        for (int j = 0; j < ARRAY_SIZE; j++)
          res_q[i][j] <= arr_c[(i*ARRAY_SIZE+j)*ACCUMULATOR_WIDTH +: ACCUMULATOR_WIDTH];
    end
  end

  assign load_ready = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign done       = done_q;
  assign error      = error_q;
  assign res_valid  = res_valid_q;
  assign res_data   = res_q[res_row][res_col];
  assign arr_clear  = arr_clear_q;
  assign arr_enable = arr_enable_q;
  assign arr_a      = arr_a_q;
  assign arr_b      = arr_b_q;

endmodule
`default_nettype wire
